mul_wb_buffer: RTL and testbench
================================

Name: mul_wb_buffer

Overview:
- Sits directly downstream of the multiply unit in the execute stage. Feeds the register-file writeback port.
- Captures the destination register tag when the multiply unit accepts an operation, then pairs it with the returned 64-bit result.
- Queues {rd, data} pairs in a small FIFO and presents them to writeback with a valid/ready handshake. Honours pipeline flush.

Parameters:
- XLEN, 64, result data width.
- REG_ADDR_W, 5, destination register index width.
- DEPTH, 2, FIFO entries; a power of two, at least 2.

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- issue_fire_i  in  1  multiply accepted an operation this cycle (mul_valid and mul_ready_o of multiply both high).
- issue_rd_i  in  REG_ADDR_W  destination register of the accepted operation.
- mul_res_valid_i  in  1  multiply result valid.
- mul_res_i  in  XLEN  multiply result.
- mul_ready_o  out  1  drives multiply's mul_ready_i.
- wb_valid_o  out  1  head entry valid toward writeback.
- wb_rd_o  out  REG_ADDR_W  head entry destination register.
- wb_data_o  out  XLEN  head entry data.
- wb_ready_i  in  1  writeback accepts the head entry.
- flush_i  in  1  pipeline flush.
- busy_o  out  1  tag pending or FIFO non-empty.
- count_o  out  $clog2(DEPTH+1)  FIFO occupancy.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset: the clock is the single clock clk; reset is synchronous and active-high.
  - On reset: tag_vld_q=0, tag_q=0, FIFO pointers and count=0, err_o=0.
  - Outputs after reset: wb_valid_o=0, wb_rd_o=0, wb_data_o=0, busy_o=0, count_o=0, mul_ready_o=1.
- Tag register:
  - issue_fire_i & ~flush_i sets tag_vld_q=1 and tag_q=issue_rd_i.
  - A push clears tag_vld_q, unless issue_fire_i is also high that cycle.
  - If push and issue_fire_i occur together, the push uses the old tag_q and the tag then loads the new value.
- Ready: mul_ready_o = ~full, purely combinational from count. There is no same-cycle bypass when full.
- Result handshake:
  - accept = mul_res_valid_i & mul_ready_o & ~flush_i.
  - If accept & tag_vld_q & tag_q!=0: push {tag_q, mul_res_i}.
  - If accept & tag_vld_q & tag_q==0 (write to x0): the handshake completes and the tag clears, but nothing is pushed.
  - If accept & ~tag_vld_q: the result is dropped and err_o is set. err_o stays set until reset.
- Pop: pop = wb_valid_o & wb_ready_i & ~flush_i.
- Writeback outputs:
  - wb_valid_o = count!=0 & ~flush_i.
  - wb_rd_o/wb_data_o come from the head entry when valid, and are 0 otherwise.
- Latency: a result accepted in cycle N appears on wb_valid_o in cycle N+1 at the earliest, with no combinational path from input to output.
- Simultaneous push and pop: allowed when not full; count is unchanged and the pointers advance.
- Full: no push and mul_ready_o=0. A pop while full frees the slot only from the next cycle.
- Empty: wb_valid_o=0. A pop request is ignored.
- Pointers: wrap modulo DEPTH. count_o ranges 0..DEPTH.
- Flush: on the next edge, clears tag_vld_q, all FIFO entries and count. A flush takes priority over any same-cycle issue, push or pop. err_o is unaffected.
- Reset mid-operation: all state returns to reset values on the next edge regardless of other inputs.
- busy_o = tag_vld_q | (count!=0).

Decomposition:
- cpu_consts:
  - REG_ADDR_W and XLEN constants.
  - mul_wb_entry_t packed struct {rd[REG_ADDR_W-1:0], data[XLEN-1:0]}.
- One sub-module: sync_fifo.
  - Parameterised generic width/depth with push/pop/clear.
  - Outputs full, empty and count.
  - Synchronous active-high reset.
  - Instantiated with mul_wb_entry_t.

Test Plan:
- Basic path: issue_fire rd=7, then result 0x0000_0000_0000_002A with wb_ready_i=1 -> next cycle wb_valid_o=1, wb_rd_o=7, wb_data_o=0x2A; popped the same cycle; count returns to 0.
- Backpressure/full, DEPTH=2:
  - Issue and return results for rd=3, rd=4 and rd=5 with wb_ready_i=0 -> count_o=2 and mul_ready_o=0, so the third result is held off.
  - Raise wb_ready_i -> rd=3, then rd=4, then rd=5 drain in order.
- x0 discard: issue rd=0 with result 0xFFFF_FFFF_FFFF_FFFF -> mul_ready_o handshake completes, count_o stays 0, wb_valid_o stays 0, busy_o drops to 0.
- Flush: two entries queued and a tag pending; assert flush_i for one cycle -> wb_valid_o=0 during the flush. Next cycle count_o=0 and busy_o=0; a subsequent result arriving without a new issue sets err_o=1.
- Simultaneous push/pop: count=1, wb_ready_i=1 and a new result rd=9 arrive in the same cycle -> count_o stays 1 and the next head is rd=9.
- Reset mid-operation: entries queued and err_o=1; assert reset for one cycle -> all outputs at reset values, mul_ready_o=1, err_o=0.

Source files
------------

// File: rtl/mul_wb_buffer_pkg.sv
// Shared constants and the writeback entry type for the multiply writeback buffer.
package mul_wb_buffer_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } mul_wb_entry_t;

endpackage

// File: rtl/mul_wb_buffer_if.sv
// Multiply-result and writeback handshakes of the multiply writeback buffer.
interface mul_wb_buffer_if;
  import mul_wb_buffer_pkg::*;

  logic                  issue_fire_i;
  logic [REG_ADDR_W-1:0] issue_rd_i;
  logic                  mul_res_valid_i;
  logic [XLEN-1:0]       mul_res_i;
  logic                  mul_ready_o;
  logic                  wb_valid_o;
  logic [REG_ADDR_W-1:0] wb_rd_o;
  logic [XLEN-1:0]       wb_data_o;
  logic                  wb_ready_i;

  modport slave (
    input  issue_fire_i, issue_rd_i, mul_res_valid_i, mul_res_i, wb_ready_i,
    output mul_ready_o, wb_valid_o, wb_rd_o, wb_data_o
  );

  modport master (
    output issue_fire_i, issue_rd_i, mul_res_valid_i, mul_res_i, wb_ready_i,
    input  mul_ready_o, wb_valid_o, wb_rd_o, wb_data_o
  );

endinterface

// File: rtl/mul_wb_buffer_sync_fifo.sv
// Generic synchronous FIFO with clear; push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mul_wb_buffer.sv
// Pairs the multiply destination tag with its returned result and queues the pair for writeback.
module mul_wb_buffer
  import mul_wb_buffer_pkg::*;
#(
  parameter int unsigned XLEN       = mul_wb_buffer_pkg::XLEN,
  parameter int unsigned REG_ADDR_W = mul_wb_buffer_pkg::REG_ADDR_W,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  mul_wb_buffer_if.slave               bus,
  input  logic                         flush_i,
  output logic                         busy_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         err_o
);

  mul_wb_entry_t         push_entry;
  mul_wb_entry_t         head;
  logic                  full, empty;
  logic                  accept, push, pop;
  logic                  tag_vld_q;
  logic [REG_ADDR_W-1:0] tag_q;

  assign bus.mul_ready_o = ~full;
  assign accept          = bus.mul_res_valid_i & ~full & ~flush_i;
  assign push            = accept & tag_vld_q & (tag_q != '0);
  assign bus.wb_valid_o  = ~empty & ~flush_i;
  assign pop             = bus.wb_valid_o & bus.wb_ready_i & ~flush_i;
  assign push_entry      = '{rd: tag_q, data: bus.mul_res_i};
  assign bus.wb_rd_o     = bus.wb_valid_o ? head.rd   : '0;
  assign bus.wb_data_o   = bus.wb_valid_o ? head.data : XLEN'(0);
  assign busy_o          = tag_vld_q | ~empty;

  sync_fifo #(
    .WIDTH ($bits(mul_wb_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush_i),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count_o)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_vld_q <= 1'b0;
      tag_q     <= '0;
    end else if (flush_i) begin
      tag_vld_q <= 1'b0;
    end else if (bus.issue_fire_i) begin
      // a same-cycle push already consumed the old tag_q
      tag_vld_q <= 1'b1;
      tag_q     <= bus.issue_rd_i;
    end else if (accept && tag_vld_q) begin
      tag_vld_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                   err_o <= 1'b0;
    else if (accept && !tag_vld_q) err_o <= 1'b1;
  end

endmodule

// File: tb/tb_mul_wb_buffer.sv
// Self-checking bench for mul_wb_buffer against a queue-based reference model.
module tb_mul_wb_buffer;
  import mul_wb_buffer_pkg::*;

  localparam int unsigned DEPTH = 2;

  typedef logic [74:0] vec_t;
  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush_i;
  logic       busy_o;
  logic       err_o;
  logic [1:0] count_o;

  int checks = 0;
  int errors = 0;

  ent_t       mq[$];
  bit         m_tag_vld;
  logic [4:0] m_tag;
  bit         m_err;

  always #5 clk = ~clk;

  mul_wb_buffer_if bus();

  mul_wb_buffer #(
    .XLEN       (64),
    .REG_ADDR_W (5),
    .DEPTH      (DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .flush_i (flush_i),
    .busy_o  (busy_o),
    .count_o (count_o),
    .err_o   (err_o)
  );

  function automatic vec_t observed();
    return {bus.wb_valid_o, bus.wb_rd_o, bus.wb_data_o, bus.mul_ready_o, busy_o, count_o, err_o};
  endfunction

  function automatic vec_t expected();
    bit          v;
    logic [4:0]  rd;
    logic [63:0] d;
    v  = (mq.size() != 0) && !flush_i;
    rd = '0;
    d  = '0;
    if (v) begin
      rd = mq[0].rd;
      d  = mq[0].data;
    end
    return {v, rd, d, mq.size() < DEPTH, m_tag_vld || (mq.size() != 0), 2'(mq.size()), m_err};
  endfunction

  task automatic model_edge();
    bit acc;
    if (reset) begin
      mq.delete();
      m_tag_vld = 0;
      m_tag     = '0;
      m_err     = 0;
    end else if (flush_i) begin
      mq.delete();
      m_tag_vld = 0;
    end else begin
      acc = bus.mul_res_valid_i && (mq.size() < DEPTH);
      if (bus.wb_ready_i && mq.size() != 0) void'(mq.pop_front());
      if (acc) begin
        if (m_tag_vld) begin
          if (m_tag != 0) mq.push_back('{m_tag, bus.mul_res_i});
          m_tag_vld = 0;
        end else begin
          m_err = 1;
        end
      end
      if (bus.issue_fire_i) begin
        m_tag_vld = 1;
        m_tag     = bus.issue_rd_i;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input bit fire, input logic [4:0] rd, input bit rv,
                        input logic [63:0] res, input bit wr, input bit fl);
    bus.issue_fire_i    = fire;
    bus.issue_rd_i      = rd;
    bus.mul_res_valid_i = rv;
    bus.mul_res_i       = res;
    bus.wb_ready_i      = wr;
    flush_i             = fl;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (observed() !== {1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values got %h exp %h", observed(), {1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 2'd0, 1'b0});
    end
    tick();
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       set_in(1, 7, 0, 0, 1, 0);
        1:       set_in(0, 0, 1, 64'h2A, 1, 0);
        default: set_in(0, 0, 0, 0, 1, 0);
      endcase
      @(negedge clk);
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL basic_step%0d got %h exp %h", i, observed(), expected());
      end
      if (i == 2) begin
        checks++;
        if ({bus.wb_valid_o, bus.wb_rd_o, bus.wb_data_o} !== {1'b1, 5'd7, 64'h2A}) begin
          errors++;
          $display("FAIL basic_head got %h exp %h", {bus.wb_valid_o, bus.wb_rd_o, bus.wb_data_o}, {1'b1, 5'd7, 64'h2A});
        end
      end
      if (i == 3) begin
        checks++;
        if (count_o !== 2'd0) begin
          errors++;
          $display("FAIL basic_drain got %0d exp 0", count_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_full();
    bit         fire [8] = '{1, 1, 1, 0, 0, 0, 0, 0};
    logic [4:0] rd   [8] = '{3, 4, 5, 0, 0, 0, 0, 0};
    bit         rv   [8] = '{0, 1, 1, 1, 1, 1, 0, 0};
    bit         wr   [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    for (int i = 0; i < 8; i++) begin
      set_in(fire[i], rd[i], rv[i], {$urandom, $urandom}, wr[i], 0);
      @(negedge clk);
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL full_step%0d got %h exp %h", i, observed(), expected());
      end
      if (i == 3) begin
        checks++;
        if ({count_o, bus.mul_ready_o} !== {2'd2, 1'b0}) begin
          errors++;
          $display("FAIL full_hold got count=%0d ready=%0b exp count=2 ready=0", count_o, bus.mul_ready_o);
        end
      end
      if (i >= 4 && i <= 6) begin
        checks++;
        if (bus.wb_rd_o !== 5'(i - 1)) begin
          errors++;
          $display("FAIL full_order%0d got %0d exp %0d", i, bus.wb_rd_o, i - 1);
        end
      end
      tick();
    end
  endtask

  task automatic test_x0();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       set_in(1, 0, 0, 0, 1, 0);
        1:       set_in(0, 0, 1, '1, 1, 0);
        default: set_in(0, 0, 0, 0, 1, 0);
      endcase
      @(negedge clk);
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL x0_step%0d got %h exp %h", i, observed(), expected());
      end
      if (i == 1) begin
        checks++;
        if (bus.mul_ready_o !== 1'b1) begin
          errors++;
          $display("FAIL x0_ready got %0b exp 1", bus.mul_ready_o);
        end
      end
      if (i == 2) begin
        checks++;
        if ({count_o, bus.wb_valid_o, busy_o} !== {2'd0, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL x0_discard got count=%0d valid=%0b busy=%0b exp 0 0 0", count_o, bus.wb_valid_o, busy_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 7; i++) begin
      case (i)
        0:       set_in(1, 1, 0, 0, 0, 0);
        1:       set_in(1, 2, 1, 64'h11, 0, 0);
        2:       set_in(1, 6, 1, 64'h22, 0, 0);
        3:       set_in(1, 12, 1, 64'h33, 1, 1);
        5:       set_in(0, 0, 1, 64'h44, 0, 0);
        default: set_in(0, 0, 0, 0, 0, 0);
      endcase
      @(negedge clk);
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL flush_step%0d got %h exp %h", i, observed(), expected());
      end
      if (i == 3) begin
        checks++;
        if (bus.wb_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL flush_valid got %0b exp 0", bus.wb_valid_o);
        end
      end
      if (i == 4) begin
        checks++;
        if ({count_o, busy_o} !== {2'd0, 1'b0}) begin
          errors++;
          $display("FAIL flush_clear got count=%0d busy=%0b exp 0 0", count_o, busy_o);
        end
      end
      if (i == 6) begin
        checks++;
        if (err_o !== 1'b1) begin
          errors++;
          $display("FAIL flush_err got %0b exp 1", err_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_push_pop();
    for (int i = 0; i < 6; i++) begin
      case (i)
        0:       set_in(1, 8, 0, 0, 0, 0);
        1:       set_in(1, 9, 1, 64'h88, 0, 0);
        2:       set_in(0, 0, 1, 64'h99, 1, 0);
        4:       set_in(0, 0, 0, 0, 1, 0);
        default: set_in(0, 0, 0, 0, 0, 0);
      endcase
      @(negedge clk);
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL pushpop_step%0d got %h exp %h", i, observed(), expected());
      end
      if (i == 3) begin
        checks++;
        if ({count_o, bus.wb_rd_o, bus.wb_data_o} !== {2'd1, 5'd9, 64'h99}) begin
          errors++;
          $display("FAIL pushpop_head got count=%0d rd=%0d data=%h exp 1 9 99", count_o, bus.wb_rd_o, bus.wb_data_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 2) == 0,
             ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
             $urandom_range(0, 1) == 1,
             {$urandom, $urandom},
             $urandom_range(0, 2) != 0,
             $urandom_range(0, 19) == 0);
      @(negedge clk);
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL random_cycle%0d got %h exp %h", i, observed(), expected());
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) begin
      reset = (i == 6);
      case (i)
        3:       set_in(1, 10, 0, 0, 0, 0);
        4:       set_in(1, 11, 1, 64'hA0, 0, 0);
        5:       set_in(0, 0, 1, 64'hB0, 0, 0);
        6:       set_in(1, 13, 1, 64'hC0, 1, 0);
        7:       set_in(0, 0, 0, 0, 0, 0);
        default: set_in(0, 0, 0, 0, 1, 0);
      endcase
      @(negedge clk);
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL resetmid_step%0d got %h exp %h", i, observed(), expected());
      end
      if (i == 6) begin
        checks++;
        if ({count_o, err_o} !== {2'd2, 1'b1}) begin
          errors++;
          $display("FAIL resetmid_pre got count=%0d err=%0b exp 2 1", count_o, err_o);
        end
      end
      if (i == 7) begin
        checks++;
        if (observed() !== {1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 2'd0, 1'b0}) begin
          errors++;
          $display("FAIL resetmid_values got %h exp %h", observed(), {1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 2'd0, 1'b0});
        end
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_x0();
    test_flush();
    test_push_pop();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
